// File: rtl/tpu_pkg.sv
// Shared TPU datapath defaults and the commit FSM state type used by the
// double-buffered weight store.
package tpu_pkg;

  localparam int TPU_DATA_W = 8;
  localparam int TPU_NUM_W  = 4;

  typedef enum logic {
    CM_IDLE    = 1'b0,
    CM_PENDING = 1'b1
  } commit_state_e;

endpackage : tpu_pkg

// File: rtl/weight_bank.sv
// One bank of NUM_W weights: single write port, every entry visible in
// parallel on a flattened read bus.
module weight_bank
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W,
  parameter int NUM_W  = TPU_NUM_W,
  parameter int ADDR_W = $clog2(NUM_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [NUM_W*DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_W];

  // NOTE: the entries are plain flops, so they take the async reset; a
  // freshly reset array must see all-zero weights rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_W; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      // Decoded per entry so an address outside 0..NUM_W-1 touches nothing.
      for (int i = 0; i < NUM_W; i++) begin
        if (waddr_i == ADDR_W'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_W; g++) begin : g_rd
    assign rdata_o[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule : weight_bank

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store: host fills the shadow bank while the array
// reads the active one; commit swaps them, deferred while the array is busy.
module weight_pingpong_buffer
  import tpu_pkg::*;
#(
  parameter int   DATA_W = TPU_DATA_W,
  parameter int   NUM_W  = TPU_NUM_W,
  localparam int  ADDR_W = $clog2(NUM_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic                    load_auto,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    commit,
  input  logic                    consumer_busy,
  output logic [NUM_W*DATA_W-1:0] weights_flat,
  output logic                    shadow_full,
  output logic                    swap_pending,
  output logic                    swap_done,
  output logic                    load_err
);

  localparam logic [ADDR_W:0]   NUM_W_EXT = (ADDR_W+1)'(NUM_W);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_W - 1);

  commit_state_e     state_q, state_d;
  logic              bank_sel_q, bank_sel_d;
  logic [NUM_W-1:0]  wr_mask_q, wr_mask_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              swap_done_q, swap_done_d;
  logic              load_err_q, load_err_d;

  logic [ADDR_W-1:0]       wr_addr;
  logic                    addr_ok;
  logic                    do_write;
  logic                    do_swap;
  logic [NUM_W*DATA_W-1:0] bank0_flat, bank1_flat;

  assign wr_addr  = load_auto ? wr_ptr_q : load_addr;
  assign addr_ok  = load_auto || ({1'b0, load_addr} < NUM_W_EXT);
  // Writes are only taken in IDLE, so a write sampled with the commit lands
  // in the bank that is about to become active.
  assign do_write = load_en && (state_q == CM_IDLE) && addr_ok;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    wr_mask_d   = wr_mask_q;
    wr_ptr_d    = wr_ptr_q;
    do_swap     = 1'b0;
    load_err_d  = load_en && ((state_q == CM_PENDING) || !addr_ok);

    unique case (state_q)
      CM_IDLE: begin
        if (commit) begin
          if (consumer_busy) state_d = CM_PENDING;
          else               do_swap = 1'b1;
        end
      end
      CM_PENDING: begin
        if (!consumer_busy) begin
          do_swap = 1'b1;
          state_d = CM_IDLE;
        end
      end
      default: state_d = CM_IDLE;
    endcase

    if (do_write) begin
      for (int i = 0; i < NUM_W; i++) begin
        if (wr_addr == ADDR_W'(i)) wr_mask_d[i] = 1'b1;
      end
      if (load_auto) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ADDR_W'(1);
    end

    // A swap overrides this cycle's mask/pointer bookkeeping.
    if (do_swap) begin
      bank_sel_d = ~bank_sel_q;
      wr_mask_d  = '0;
      wr_ptr_d   = '0;
    end

    swap_done_d = do_swap;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CM_IDLE;
      bank_sel_q  <= 1'b0;
      wr_mask_q   <= '0;
      wr_ptr_q    <= '0;
      swap_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      wr_mask_q   <= wr_mask_d;
      wr_ptr_q    <= wr_ptr_d;
      swap_done_q <= swap_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // The shadow is whichever bank bank_sel_q does not point at.
  weight_bank #(.DATA_W(DATA_W), .NUM_W(NUM_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (do_write && bank_sel_q),
    .waddr_i (wr_addr),
    .wdata_i (load_data),
    .rdata_o (bank0_flat)
  );

  weight_bank #(.DATA_W(DATA_W), .NUM_W(NUM_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (do_write && !bank_sel_q),
    .waddr_i (wr_addr),
    .wdata_i (load_data),
    .rdata_o (bank1_flat)
  );

  assign weights_flat = bank_sel_q ? bank1_flat : bank0_flat;
  assign shadow_full  = &wr_mask_q;
  assign swap_pending = (state_q == CM_PENDING);
  assign swap_done    = swap_done_q;
  assign load_err     = load_err_q;

endmodule : weight_pingpong_buffer

// File: tb/tb_weight_pingpong_buffer.sv
// Bench for weight_pingpong_buffer: a 4-entry instance against a behavioural
// bank/mask/pointer model, plus a 3-entry instance for range and partial commits.
module tb_weight_pingpong_buffer;

  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int AW  = 2;
  localparam int NW3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-entry instance
  logic             rst, load_en, load_auto, commit, consumer_busy;
  logic [AW-1:0]    load_addr;
  logic [DW-1:0]    load_data;
  logic [NW*DW-1:0] weights_flat;
  logic             shadow_full, swap_pending, swap_done, load_err;

  // 3-entry instance
  logic              rst3, load_en3, load_auto3, commit3, busy3;
  logic [1:0]        load_addr3;
  logic [DW-1:0]     load_data3;
  logic [NW3*DW-1:0] weights_flat3;
  logic              shadow_full3, swap_pending3, swap_done3, load_err3;

  weight_pingpong_buffer #(.DATA_W(DW), .NUM_W(NW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_auto(load_auto),
    .load_addr(load_addr), .load_data(load_data), .commit(commit),
    .consumer_busy(consumer_busy), .weights_flat(weights_flat),
    .shadow_full(shadow_full), .swap_pending(swap_pending),
    .swap_done(swap_done), .load_err(load_err)
  );

  weight_pingpong_buffer #(.DATA_W(DW), .NUM_W(NW3)) dut3 (
    .clk(clk), .rst(rst3), .load_en(load_en3), .load_auto(load_auto3),
    .load_addr(load_addr3), .load_data(load_data3), .commit(commit3),
    .consumer_busy(busy3), .weights_flat(weights_flat3),
    .shadow_full(shadow_full3), .swap_pending(swap_pending3),
    .swap_done(swap_done3), .load_err(load_err3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two banks as arrays, index of active bank, written set.
  logic [DW-1:0] m_bank [2][NW];
  int            m_act;
  bit            m_written [NW];
  int            m_ptr;
  bit            m_pend, m_done, m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NW; i++) m_bank[b][i] = '0;
    for (int i = 0; i < NW; i++) m_written[i] = 1'b0;
    m_act = 0; m_ptr = 0; m_pend = 0; m_done = 0; m_err = 0;
  endtask

  // One clock edge of the specified behaviour, from the inputs held at it.
  task automatic model_step(input bit le, input bit la, input int addr,
                            input logic [DW-1:0] data, input bit cm, input bit busy);
    int  a;
    bit  swap_now;
    a        = la ? m_ptr : addr;
    m_err    = le && (m_pend || (!la && addr >= NW));
    swap_now = m_pend ? !busy : (cm && !busy);
    if (le && !m_err) begin
      m_bank[1 - m_act][a] = data;
      m_written[a] = 1'b1;
      if (la) m_ptr = (m_ptr + 1) % NW;
    end
    if (!m_pend && cm && busy) m_pend = 1'b1;
    m_done = swap_now;
    if (swap_now) begin
      m_act  = 1 - m_act;
      m_pend = 1'b0;
      m_ptr  = 0;
      for (int i = 0; i < NW; i++) m_written[i] = 1'b0;
    end
  endtask

  function automatic logic [NW*DW-1:0] model_flat();
    logic [NW*DW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*DW +: DW] = m_bank[m_act][i];
    return r;
  endfunction

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < NW; i++) f &= m_written[i];
    return f;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".weights"}, 64'(weights_flat), 64'(model_flat()));
    check({tag, ".full"},    64'(shadow_full),  64'(model_full()));
    check({tag, ".pending"}, 64'(swap_pending), 64'(m_pend));
    check({tag, ".done"},    64'(swap_done),    64'(m_done));
    check({tag, ".err"},     64'(load_err),     64'(m_err));
  endtask

  task automatic drive(input bit le, input bit la, input int addr,
                       input logic [DW-1:0] data, input bit cm, input bit busy);
    load_en = le; load_auto = la; load_addr = AW'(addr);
    load_data = data; commit = cm; consumer_busy = busy;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step(load_en, load_auto, int'(load_addr), load_data, commit, consumer_busy);
    check_all(tag);
  endtask

  task automatic drive3(input bit le, input bit la, input int addr,
                        input logic [DW-1:0] data, input bit cm);
    load_en3 = le; load_auto3 = la; load_addr3 = 2'(addr);
    load_data3 = data; commit3 = cm; busy3 = 1'b0;
  endtask

  task automatic tick3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 0);
    drive3(0, 0, 0, 8'h00, 0);
    model_reset();
    #12;
    check_all("reset");
    check("reset.flat3", 64'(weights_flat3), 64'h0);
    rst = 1'b0; rst3 = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0);
    tick("idle");

    // Auto-load a full bank and commit with the array idle.
    for (int i = 0; i < NW; i++) begin
      drive(1, 1, 0, DW'(8'h11 * (i + 1)), 0, 0);
      tick("autoload");
    end
    check("autoload.full_after_4", 64'(shadow_full), 64'h1);
    drive(0, 0, 0, 8'h00, 1, 0);
    tick("commit_imm");
    check("commit_imm.flat", 64'(weights_flat), 64'h44332211);
    check("commit_imm.done", 64'(swap_done), 64'h1);
    drive(0, 0, 0, 8'h00, 0, 0);
    tick("after_commit");
    check("after_commit.done_low", 64'(swap_done), 64'h0);
    check("after_commit.full_low", 64'(shadow_full), 64'h0);

    // Deferred swap; the write one cycle after the commit is dropped.
    drive(0, 0, 0, 8'h00, 1, 1);
    tick("defer_commit");
    check("defer.pending", 64'(swap_pending), 64'h1);
    drive(1, 1, 0, 8'h55, 0, 1);
    tick("defer_drop");
    check("defer.load_err", 64'(load_err), 64'h1);
    check("defer.flat_kept", 64'(weights_flat), 64'h44332211);
    drive(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) tick("defer_wait");
    drive(0, 0, 0, 8'h00, 0, 0);
    tick("defer_release");
    check("defer.pending_low", 64'(swap_pending), 64'h0);
    check("defer.done", 64'(swap_done), 64'h1);

    // Write and commit in the same cycle.
    drive(1, 0, 2, 8'hAA, 1, 0);
    tick("wr_and_commit");
    check("wr_and_commit.flat", 64'(weights_flat), 64'h44AA2211);

    // Auto pointer wraps: the 5th write overwrites entry 0.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0, DW'(i), 0, 0);
      tick("wrap_load");
    end
    drive(0, 0, 0, 8'h00, 1, 0);
    tick("wrap_commit");
    check("wrap.weight0", 64'(weights_flat[7:0]), 64'h05);
    drive(1, 1, 0, 8'h77, 0, 0);
    tick("ptr_after_swap");
    drive(0, 0, 0, 8'h00, 1, 0);
    tick("ptr_commit");
    check("ptr_after_swap.flat", 64'(weights_flat), 64'h44AA2277);

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1), $urandom_range(0, NW - 1),
            DW'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3));
      tick("random");
    end

    // Reset while a swap is pending clears everything at once.
    drive(0, 0, 0, 8'h00, 0, 0);
    tick("pre_rst");
    drive(1, 1, 0, 8'h9C, 1, 1);
    tick("rst_pend_commit");
    drive(0, 0, 0, 8'h00, 0, 1);
    tick("rst_pend_wait");
    check("rst_pend.pending", 64'(swap_pending), 64'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.flat_zero", 64'(weights_flat), 64'h0);
    #3 rst = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) tick("post_rst");

    // 3-entry instance: out-of-range explicit address is dropped.
    drive3(1, 0, 3, 8'hEE, 0);
    tick3();
    check("n3.range_err", 64'(load_err3), 64'h1);
    check("n3.range_full", 64'(shadow_full3), 64'h0);
    drive3(0, 0, 0, 8'h00, 0);
    tick3();
    check("n3.err_pulse", 64'(load_err3), 64'h0);
    for (int i = 0; i < NW3; i++) begin
      drive3(1, 0, i, DW'(8'hA0 + i), 0);
      tick3();
    end
    check("n3.full", 64'(shadow_full3), 64'h1);
    drive3(0, 0, 0, 8'h00, 1);
    tick3();
    check("n3.first_commit", 64'(weights_flat3), 64'hA2A1A0);
    check("n3.done", 64'(swap_done3), 64'h1);
    for (int i = 0; i < 4; i++) begin
      drive3(1, 1, 0, DW'(8'hB0 + i), 0);
      tick3();
    end
    drive3(0, 0, 0, 8'h00, 1);
    tick3();
    check("n3.auto_wrap", 64'(weights_flat3), 64'hB2B1B3);
    drive3(1, 0, 1, 8'hCC, 1);
    tick3();
    check("n3.partial", 64'(weights_flat3), 64'hA2CCA0);
    drive3(0, 0, 0, 8'h00, 0);
    tick3();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_weight_pingpong_buffer
